// File: rtl/mstr_out_buffer.sv
// Output buffer for the image processing accelerator master port.
// A first-word-fall-through FIFO absorbs master backpressure. Each word carries
// a one-hot tag that names its originating slave. A small frame tracker counts
// the words the master has taken and pulses mstr0_cmplt once per delivered frame.
module mstr_out_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_src,
  input  logic                  in_last,
  output logic                  in_rdy,
  input  logic                  mstr0_rdy,
  output logic [DATA_WIDTH-1:0] mstr0_data,
  output logic [1:0]            mstr0_data_valid,
  output logic                  mstr0_cmplt,
  output logic [CNT_WIDTH-1:0]  frame_words
);

  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_WIDTH + 2;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Storage layout of each entry: {last, src, data}
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] frame_words_reg;
  logic                 cmplt_reg;

  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic               head_last;
  logic               head_src;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);

  // in_rdy depends only on the registered count, never on the master handshake,
  // so a full buffer refuses a push even in a cycle in which it also pops.
  assign in_rdy = !full;
  assign push   = in_vld && !full;
  assign pop    = !empty && mstr0_rdy;

  assign head      = mem[rd_ptr_reg];
  assign head_last = head[ENTRY_W-1];
  assign head_src  = head[ENTRY_W-2];

  assign mstr0_data       = empty ? '0 : head[DATA_WIDTH-1:0];
  assign mstr0_data_valid = empty ? 2'b00 : (head_src ? 2'b10 : 2'b01);
  assign mstr0_cmplt      = cmplt_reg;
  assign frame_words      = frame_words_reg;

  // Entry storage: write only, no reset. Stale entries are never visible
  // because the outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_last, in_src, in_data};
    end
  end

  // Pointer and occupancy bookkeeping. Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Frame tracker: counts popped words and raises a one-cycle completion pulse
  // after the pop of a word marked last. It only observes pops and never stalls them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      frame_words_reg <= '0;
      cmplt_reg       <= 1'b0;
    end else begin
      cmplt_reg <= 1'b0;
      if (pop) begin
        // A pop outside BUSY opens a new frame. That includes the DONE cycle.
        if (state_reg == BUSY) begin
          if (!(&frame_words_reg)) begin
            frame_words_reg <= frame_words_reg + 1'b1;
          end
        end else begin
          frame_words_reg <= CNT_WIDTH'(1);
        end
        if (head_last) begin
          state_reg <= DONE;
          cmplt_reg <= 1'b1;
        end else begin
          state_reg <= BUSY;
        end
      end else if (state_reg == DONE) begin
        state_reg <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mstr_out_buffer.sv
// Directed testbench for mstr_out_buffer: one task per scenario, inline checks.
module tb_mstr_out_buffer;

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic [31:0] in_data;
  logic        in_src;
  logic        in_last;
  logic        in_rdy;
  logic        mstr0_rdy;
  logic [31:0] mstr0_data;
  logic [1:0]  mstr0_data_valid;
  logic        mstr0_cmplt;
  logic [15:0] frame_words;

  int tests_run = 0;
  int tests_failed = 0;

  mstr_out_buffer #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(8),
    .CNT_WIDTH (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_vld          (in_vld),
    .in_data         (in_data),
    .in_src          (in_src),
    .in_last         (in_last),
    .in_rdy          (in_rdy),
    .mstr0_rdy       (mstr0_rdy),
    .mstr0_data      (mstr0_data),
    .mstr0_data_valid(mstr0_data_valid),
    .mstr0_cmplt     (mstr0_cmplt),
    .frame_words     (frame_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before anything is sampled or driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    tests_run++; if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
    tests_run++; if (mstr0_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data got=%h exp=0", mstr0_data); end
    tests_run++; if (mstr0_data_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_valid got=%b exp=00", mstr0_data_valid); end
    tests_run++; if (mstr0_cmplt !== 1'b0) begin tests_failed++; $display("FAIL reset_cmplt got=%b exp=0", mstr0_cmplt); end
    tests_run++; if (frame_words !== 16'd0) begin tests_failed++; $display("FAIL reset_frame_words got=%0d exp=0", frame_words); end
    rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_word();
    in_vld = 1'b1; in_data = 32'hA1B2C3D4; in_src = 1'b0; in_last = 1'b1; mstr0_rdy = 1'b1;
    step();
    in_vld = 1'b0;
    tests_run++; if (mstr0_data !== 32'hA1B2C3D4) begin tests_failed++; $display("FAIL single_data got=%h exp=a1b2c3d4", mstr0_data); end
    tests_run++; if (mstr0_data_valid !== 2'b01) begin tests_failed++; $display("FAIL single_valid got=%b exp=01", mstr0_data_valid); end
    tests_run++; if (mstr0_cmplt !== 1'b0) begin tests_failed++; $display("FAIL single_cmplt_early got=%b exp=0", mstr0_cmplt); end
    step();
    tests_run++; if (mstr0_cmplt !== 1'b1) begin tests_failed++; $display("FAIL single_cmplt got=%b exp=1", mstr0_cmplt); end
    tests_run++; if (frame_words !== 16'd1) begin tests_failed++; $display("FAIL single_frame_words got=%0d exp=1", frame_words); end
    tests_run++; if (mstr0_data_valid !== 2'b00) begin tests_failed++; $display("FAIL single_drained got=%b exp=00", mstr0_data_valid); end
    step();
    tests_run++; if (mstr0_cmplt !== 1'b0) begin tests_failed++; $display("FAIL single_cmplt_width got=%b exp=0", mstr0_cmplt); end
    tests_run++; if (frame_words !== 16'd1) begin tests_failed++; $display("FAIL single_frame_words_hold got=%0d exp=1", frame_words); end
    $display("[TB] test_single_word done");
  endtask

  task automatic test_fill();
    mstr0_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_vld = 1'b1; in_data = 32'h1000_0000 + i; in_src = i[0]; in_last = (i == 7);
      step();
    end
    tests_run++; if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL fill_full got=%b exp=0", in_rdy); end
    // Ninth word offered while full must be ignored.
    in_data = 32'hDEAD_BEEF; in_src = 1'b0; in_last = 1'b0;
    step();
    tests_run++; if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL fill_still_full got=%b exp=0", in_rdy); end
    tests_run++; if (mstr0_data !== 32'h1000_0000) begin tests_failed++; $display("FAIL fill_head_stable got=%h exp=10000000", mstr0_data); end
    mstr0_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      // In the first drain cycle the extra word is still offered: pop while full must not push.
      in_vld = (i == 0);
      tests_run++; if (mstr0_data !== 32'h1000_0000 + i) begin tests_failed++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, mstr0_data, 32'h1000_0000 + i); end
      tests_run++; if (mstr0_data_valid !== (i[0] ? 2'b10 : 2'b01)) begin tests_failed++; $display("FAIL fill_tag[%0d] got=%b exp=%b", i, mstr0_data_valid, (i[0] ? 2'b10 : 2'b01)); end
      step();
    end
    in_vld = 1'b0;
    tests_run++; if (mstr0_data_valid !== 2'b00) begin tests_failed++; $display("FAIL fill_empty got=%b exp=00", mstr0_data_valid); end
    tests_run++; if (mstr0_cmplt !== 1'b1) begin tests_failed++; $display("FAIL fill_cmplt got=%b exp=1", mstr0_cmplt); end
    tests_run++; if (frame_words !== 16'd8) begin tests_failed++; $display("FAIL fill_frame_words got=%0d exp=8", frame_words); end
    mstr0_rdy = 1'b0;
    step();
    $display("[TB] test_fill done");
  endtask

  task automatic test_push_pop();
    mstr0_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_data = 32'h2000 + i; in_src = 1'b0; in_last = 1'b0;
      step();
    end
    mstr0_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_vld = 1'b1; in_data = 32'h2004 + k; in_last = (k == 19);
      tests_run++; if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL pushpop_rdy[%0d] got=%b exp=1", k, in_rdy); end
      tests_run++; if (mstr0_data !== 32'h2000 + k) begin tests_failed++; $display("FAIL pushpop_order[%0d] got=%h exp=%h", k, mstr0_data, 32'h2000 + k); end
      step();
    end
    in_vld = 1'b0; in_last = 1'b0;
    // Exactly four entries must remain after the steady-state phase.
    for (int j = 0; j < 4; j++) begin
      tests_run++; if (mstr0_data !== 32'h2014 + j) begin tests_failed++; $display("FAIL pushpop_drain[%0d] got=%h exp=%h", j, mstr0_data, 32'h2014 + j); end
      step();
    end
    tests_run++; if (mstr0_data_valid !== 2'b00) begin tests_failed++; $display("FAIL pushpop_empty got=%b exp=00", mstr0_data_valid); end
    tests_run++; if (mstr0_cmplt !== 1'b1) begin tests_failed++; $display("FAIL pushpop_cmplt got=%b exp=1", mstr0_cmplt); end
    tests_run++; if (frame_words !== 16'd24) begin tests_failed++; $display("FAIL pushpop_frame_words got=%0d exp=24", frame_words); end
    mstr0_rdy = 1'b0;
    step();
    $display("[TB] test_push_pop done");
  endtask

  task automatic test_stall();
    int idx;
    int pulses;
    mstr0_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_data = 32'h3000 + i; in_src = 1'b1; in_last = (i == 4);
      step();
    end
    in_vld = 1'b0; in_last = 1'b0;
    idx = 0; pulses = 0;
    for (int c = 0; c < 9; c++) begin
      mstr0_rdy = (c % 2 == 0);
      tests_run++; if (mstr0_data !== 32'h3000 + idx) begin tests_failed++; $display("FAIL stall_data[%0d] got=%h exp=%h", c, mstr0_data, 32'h3000 + idx); end
      tests_run++; if (mstr0_data_valid !== 2'b10) begin tests_failed++; $display("FAIL stall_tag[%0d] got=%b exp=10", c, mstr0_data_valid); end
      step();
      if (mstr0_cmplt) pulses++;
      if (c % 2 == 0) idx++;
    end
    tests_run++; if (frame_words !== 16'd5) begin tests_failed++; $display("FAIL stall_frame_words got=%0d exp=5", frame_words); end
    mstr0_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (mstr0_cmplt) pulses++;
    end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL stall_pulses got=%0d exp=1", pulses); end
    tests_run++; if (mstr0_data_valid !== 2'b00) begin tests_failed++; $display("FAIL stall_empty got=%b exp=00", mstr0_data_valid); end
    $display("[TB] test_stall done");
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [15:0] fw_seen [2];
    pulses = 0;
    fw_seen[0] = '0; fw_seen[1] = '0;
    mstr0_rdy = 1'b1;
    for (int s = 0; s < 8; s++) begin
      in_vld = (s < 5); in_data = 32'h4000 + s; in_src = s[0]; in_last = (s == 2) || (s == 4);
      step();
      if (mstr0_cmplt) begin
        if (pulses < 2) fw_seen[pulses] = frame_words;
        pulses++;
      end
    end
    in_vld = 1'b0; in_last = 1'b0;
    tests_run++; if (pulses !== 2) begin tests_failed++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    tests_run++; if (fw_seen[0] !== 16'd3) begin tests_failed++; $display("FAIL b2b_frame0_words got=%0d exp=3", fw_seen[0]); end
    tests_run++; if (fw_seen[1] !== 16'd2) begin tests_failed++; $display("FAIL b2b_frame1_words got=%0d exp=2", fw_seen[1]); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_reset_mid_frame();
    logic bad;
    mstr0_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_data = 32'h5000 + i; in_src = 1'b0; in_last = 1'b0;
      step();
    end
    in_vld = 1'b0;
    mstr0_rdy = 1'b1;
    step();
    mstr0_rdy = 1'b0;
    tests_run++; if (frame_words !== 16'd1) begin tests_failed++; $display("FAIL midrst_started got=%0d exp=1", frame_words); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++; if (mstr0_data_valid !== 2'b00) begin tests_failed++; $display("FAIL midrst_valid got=%b exp=00", mstr0_data_valid); end
    tests_run++; if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_rdy got=%b exp=1", in_rdy); end
    tests_run++; if (mstr0_cmplt !== 1'b0) begin tests_failed++; $display("FAIL midrst_cmplt got=%b exp=0", mstr0_cmplt); end
    tests_run++; if (frame_words !== 16'd0) begin tests_failed++; $display("FAIL midrst_frame_words got=%0d exp=0", frame_words); end
    mstr0_rdy = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (mstr0_cmplt !== 1'b0 || mstr0_data_valid !== 2'b00) bad = 1'b1;
    end
    tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL midrst_quiet got=%b exp=0", bad); end
    $display("[TB] test_reset_mid_frame done");
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_data = '0; in_src = 1'b0; in_last = 1'b0; mstr0_rdy = 1'b0;
    test_reset();
    test_single_word();
    test_fill();
    test_push_pop();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
